// File: rtl/imem_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
//   Shared definitions for the PE instruction-memory bank controller:
//   default geometry, index/length typedefs for that geometry and the
//   wrapped bank-pointer increment used by both the top level and the bank
//   bookkeeping FIFO.
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

    // Default geometry (modules take these as parameter defaults).
    localparam int unsigned DEF_INST_WIDTH = 64;
    localparam int unsigned DEF_INST_WORD  = 32;
    localparam int unsigned DEF_NUM_BANK   = 3;
    localparam int unsigned DEF_ID         = 3;

    localparam int unsigned DEF_BANK_W = $clog2(DEF_NUM_BANK);
    localparam int unsigned DEF_WORD_W = $clog2(DEF_INST_WORD);
    localparam int unsigned DEF_LEN_W  = DEF_WORD_W + 1;

    // Index and length types for the default geometry.
    typedef logic [DEF_BANK_W-1:0] bank_idx_t;
    typedef logic [DEF_WORD_W-1:0] word_idx_t;
    typedef logic [DEF_LEN_W-1:0]  len_t;

    // Next bank pointer: ptr + 1, wrapping num_bank-1 back to 0.
    function automatic int unsigned bank_inc(input int unsigned ptr,
                                             input int unsigned num_bank);
        return (ptr >= num_bank - 1) ? 0 : ptr + 1;
    endfunction

endpackage : imem_ctrl_pkg

// File: rtl/imem_bank_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_bank_ctrl_if
//   Bundles the Program Launcher stream, the bank SRAM write port and the PE
//   fetch-side signals of one imem_bank_ctrl.
//   Handshake: a PL word transfers on a rising clk edge where pl_valid_i,
//   pl_ready_o are both 1 and pl_id_i matches the controller ID; words with
//   another id are dropped regardless of pl_ready_o, and pl_ready_o never
//   depends on pl_id_i or on pl_valid_i.
//   modport master : PL + PE side (drives *_i, observes *_o)
//   modport slave  : controller side
// -----------------------------------------------------------------------------
interface imem_bank_ctrl_if #(
    parameter int unsigned INST_WIDTH = 64,
    parameter int unsigned INST_WORD  = 32,
    parameter int unsigned NUM_BANK   = 3
);
    // PL stream
    logic                          pl_valid_i;
    logic [1:0]                    pl_id_i;
    logic                          pl_last_i;
    logic [INST_WIDTH-1:0]         pl_data_i;
    logic                          pl_ready_o;
    // bank write port
    logic                          wr_en_o;
    logic [$clog2(NUM_BANK)-1:0]   wr_bank_o;
    logic [$clog2(INST_WORD)-1:0]  wr_addr_o;
    logic [INST_WIDTH-1:0]         wr_data_o;
    logic                          wr_switch_o;
    // PE fetch side
    logic                          pe_done_i;
    logic                          rd_valid_o;
    logic [$clog2(NUM_BANK)-1:0]   rd_bank_o;
    logic [$clog2(INST_WORD):0]    rd_len_o;
    logic                          rd_switch_o;
    logic                          ovf_o;

    modport master (
        output pl_valid_i, pl_id_i, pl_last_i, pl_data_i, pe_done_i,
        input  pl_ready_o, wr_en_o, wr_bank_o, wr_addr_o, wr_data_o,
               wr_switch_o, rd_valid_o, rd_bank_o, rd_len_o, rd_switch_o, ovf_o
    );

    modport slave (
        input  pl_valid_i, pl_id_i, pl_last_i, pl_data_i, pe_done_i,
        output pl_ready_o, wr_en_o, wr_bank_o, wr_addr_o, wr_data_o,
               wr_switch_o, rd_valid_o, rd_bank_o, rd_len_o, rd_switch_o, ovf_o
    );
endinterface : imem_bank_ctrl_if

// File: rtl/imem_bank_fifo.sv
// -----------------------------------------------------------------------------
// imem_bank_fifo
//   Bank bookkeeping: write pointer, read pointer, count of complete programs
//   and the per-bank program length table.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_commit        closed program becomes visible this edge (wr_ptr++, count++)
//     i_len_we        record a program length into the bank being filled
//     i_len_wdata     length to record
//     i_pe_done       PE finished the program in rd bank
//     o_wr_bank       bank that the next accepted word goes to
//     o_pl_ready      a further word can be accepted
//     o_rd_valid      rd bank holds a complete program
//     o_rd_bank       bank the PE fetches from
//     o_rd_len        length of the program in rd bank
//     o_rd_switch     one-cycle pulse after rd bank release
// -----------------------------------------------------------------------------
module imem_bank_fifo
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned INST_WORD = DEF_INST_WORD,
    parameter int unsigned NUM_BANK  = DEF_NUM_BANK
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_commit,
    input  logic                          i_len_we,
    input  logic [$clog2(INST_WORD):0]    i_len_wdata,
    input  logic                          i_pe_done,
    output logic [$clog2(NUM_BANK)-1:0]   o_wr_bank,
    output logic                          o_pl_ready,
    output logic                          o_rd_valid,
    output logic [$clog2(NUM_BANK)-1:0]   o_rd_bank,
    output logic [$clog2(INST_WORD):0]    o_rd_len,
    output logic                          o_rd_switch
);
    localparam int unsigned BANK_W = $clog2(NUM_BANK);
    localparam int unsigned LEN_W  = $clog2(INST_WORD) + 1;
    localparam int unsigned CNT_W  = $clog2(NUM_BANK + 1);

    logic [BANK_W-1:0] r_wr_ptr;
    logic [BANK_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_switch;
    logic [LEN_W-1:0]  r_len [NUM_BANK];

    logic              w_release;
    logic [BANK_W-1:0] w_wr_ptr_next;
    logic [BANK_W-1:0] w_rd_ptr_next;

    assign w_wr_ptr_next = BANK_W'(bank_inc(32'(r_wr_ptr), NUM_BANK));
    assign w_rd_ptr_next = BANK_W'(bank_inc(32'(r_rd_ptr), NUM_BANK));
    assign w_release     = i_pe_done && (r_count != '0);

    // While a commit is pending, wr_ptr still names the closed bank; a word
    // accepted in that cycle already belongs to the following bank.
    assign o_wr_bank   = i_commit ? w_wr_ptr_next : r_wr_ptr;

    // Pending commit counts as occupied so back-to-back closes cannot
    // overrun the read bank.
    assign o_pl_ready  = (32'(r_count) + 32'(i_commit)) < NUM_BANK;
    assign o_rd_valid  = (r_count != '0);
    assign o_rd_bank   = r_rd_ptr;
    assign o_rd_len    = r_len[r_rd_ptr];
    assign o_rd_switch = r_rd_switch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_switch <= 1'b0;
            for (int i = 0; i < int'(NUM_BANK); i++) begin
                r_len[i] <= '0;
            end
        end else begin
            r_rd_switch <= w_release;
            if (i_commit) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_release) begin
                r_rd_ptr        <= w_rd_ptr_next;
                r_len[r_rd_ptr] <= '0;
            end
            case ({i_commit, w_release})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The filled bank never equals the released one: a release needs
            // count > 0 and an accept needs count + pending < NUM_BANK.
            if (i_len_we) begin
                r_len[o_wr_bank] <= i_len_wdata;
            end
        end
    end

endmodule : imem_bank_fifo

// File: rtl/imem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// imem_bank_ctrl
//   Instruction-memory bank sequencer for one PE. Accepts the PL word stream,
//   writes each word to the next free bank through a one-stage registered
//   write port, closes a program on pl_last_i or when a bank fills, and hands
//   complete programs to the PE oldest first.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          imem_bank_ctrl_if.slave (PL stream, write port, PE side)
// -----------------------------------------------------------------------------
module imem_bank_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
    parameter int unsigned INST_WORD  = DEF_INST_WORD,
    parameter int unsigned NUM_BANK   = DEF_NUM_BANK,
    parameter int unsigned ID         = DEF_ID
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_bank_ctrl_if.slave  bus
);
    localparam int unsigned BANK_W = $clog2(NUM_BANK);
    localparam int unsigned WORD_W = $clog2(INST_WORD);
    localparam int unsigned LEN_W  = WORD_W + 1;

    logic [WORD_W-1:0]     r_index;
    logic                  r_commit_pending;
    logic                  r_wr_en;
    logic [BANK_W-1:0]     r_wr_bank;
    logic [WORD_W-1:0]     r_wr_addr;
    logic [INST_WIDTH-1:0] r_wr_data;
    logic                  r_wr_switch;
    logic                  r_ovf;

    logic                  w_pl_ready;
    logic                  w_accept;
    logic                  w_at_end;
    logic                  w_close;
    logic [BANK_W-1:0]     w_wr_bank;
    logic [LEN_W-1:0]      w_len;

    assign w_accept = bus.pl_valid_i && (bus.pl_id_i == 2'(ID)) && w_pl_ready;
    assign w_at_end = (r_index == WORD_W'(INST_WORD - 1));
    assign w_close  = w_accept && (bus.pl_last_i || w_at_end);
    assign w_len    = LEN_W'(r_index) + LEN_W'(1);

    imem_bank_fifo #(
        .INST_WORD (INST_WORD),
        .NUM_BANK  (NUM_BANK)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_commit    (r_commit_pending),
        .i_len_we    (w_close),
        .i_len_wdata (w_len),
        .i_pe_done   (bus.pe_done_i),
        .o_wr_bank   (w_wr_bank),
        .o_pl_ready  (w_pl_ready),
        .o_rd_valid  (bus.rd_valid_o),
        .o_rd_bank   (bus.rd_bank_o),
        .o_rd_len    (bus.rd_len_o),
        .o_rd_switch (bus.rd_switch_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index          <= '0;
            r_commit_pending <= 1'b0;
            r_wr_en          <= 1'b0;
            r_wr_bank        <= '0;
            r_wr_addr        <= '0;
            r_wr_data        <= '0;
            r_wr_switch      <= 1'b0;
            r_ovf            <= 1'b0;
        end else begin
            r_wr_en          <= w_accept;
            r_commit_pending <= w_close;
            r_wr_switch      <= r_commit_pending;
            if (w_accept) begin
                r_wr_bank <= w_wr_bank;
                r_wr_addr <= r_index;
                r_wr_data <= bus.pl_data_i;
            end
            if (w_close) begin
                r_index <= '0;
            end else if (w_accept) begin
                r_index <= r_index + 1'b1;
            end
            // A full bank without pl_last_i truncates the program; sticky.
            if (w_accept && w_at_end && !bus.pl_last_i) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.pl_ready_o  = w_pl_ready;
    assign bus.wr_en_o     = r_wr_en;
    assign bus.wr_bank_o   = r_wr_bank;
    assign bus.wr_addr_o   = r_wr_addr;
    assign bus.wr_data_o   = r_wr_data;
    assign bus.wr_switch_o = r_wr_switch;
    assign bus.ovf_o       = r_ovf;

endmodule : imem_bank_ctrl

// File: tb/tb_imem_bank_ctrl.sv
module tb_imem_bank_ctrl;
  import imem_ctrl_pkg::*;

  localparam int W  = 64;
  localparam int NW = 32;
  localparam int NB = 3;
  localparam int ID = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_bank_ctrl_if #(.INST_WIDTH(W), .INST_WORD(NW), .NUM_BANK(NB)) bus ();

  imem_bank_ctrl #(.INST_WIDTH(W), .INST_WORD(NW), .NUM_BANK(NB), .ID(ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Committed programs are a queue of lengths, oldest first; the k-th entry
  // lives in bank (m_rd + k) mod NB. A just-closed program spends one cycle
  // as "pending" before it joins the queue.
  int          m_q[$];
  int          m_rd;
  int          m_pend;      // 0 = none, else length of the closing program
  int          m_idx;
  bit          m_ovf;
  bit          e_wr_en;
  int          e_wr_bank;
  int          e_wr_addr;
  logic [W-1:0] e_wr_data;
  bit          e_wr_sw;
  bit          e_rd_sw;

  function automatic bit m_ready();
    return (m_q.size() + ((m_pend != 0) ? 1 : 0)) < NB;
  endfunction

  function automatic int m_rd_len();
    if (m_q.size() != 0) return m_q[0];
    return m_pend;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rd = 0; m_pend = 0; m_idx = 0; m_ovf = 0;
    e_wr_en = 0; e_wr_bank = 0; e_wr_addr = 0; e_wr_data = '0;
    e_wr_sw = 0; e_rd_sw = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pl_ready",  W'(bus.pl_ready_o),  W'(m_ready()));
    chk("wr_en",     W'(bus.wr_en_o),     W'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_bank", W'(bus.wr_bank_o),   W'(e_wr_bank));
      chk("wr_addr", W'(bus.wr_addr_o),   W'(e_wr_addr));
      chk("wr_data", bus.wr_data_o,       e_wr_data);
    end
    chk("wr_switch", W'(bus.wr_switch_o), W'(e_wr_sw));
    chk("rd_valid",  W'(bus.rd_valid_o),  W'(m_q.size() != 0));
    chk("rd_bank",   W'(bus.rd_bank_o),   W'(m_rd));
    chk("rd_len",    W'(bus.rd_len_o),    W'(m_rd_len()));
    chk("rd_switch", W'(bus.rd_switch_o), W'(e_rd_sw));
    chk("ovf",       W'(bus.ovf_o),       W'(m_ovf));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model across the next
  // rising edge, then compare at the following falling edge.
  task automatic step(input bit v, input int id, input bit last,
                      input logic [W-1:0] d, input bit done, output bit acc);
    int wbank;
    int pend_pre;
    bit rel;
    bus.pl_valid_i = v;
    bus.pl_id_i    = 2'(id);
    bus.pl_last_i  = last;
    bus.pl_data_i  = d;
    bus.pe_done_i  = done;
    acc      = v && (id == ID) && m_ready();
    rel      = done && (m_q.size() != 0);
    wbank    = (m_rd + m_q.size() + ((m_pend != 0) ? 1 : 0)) % NB;
    pend_pre = m_pend;
    @(posedge clk);
    e_wr_en = acc;
    if (acc) begin
      e_wr_bank = wbank;
      e_wr_addr = m_idx;
      e_wr_data = d;
    end
    e_wr_sw = (pend_pre != 0);
    e_rd_sw = rel;
    if (rel) begin
      void'(m_q.pop_front());
      m_rd = (m_rd + 1) % NB;
    end
    if (pend_pre != 0) m_q.push_back(pend_pre);
    m_pend = 0;
    if (acc) begin
      if (last || m_idx == NW - 1) begin
        if (!last) m_ovf = 1;
        m_pend = m_idx + 1;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, acc);
  endtask

  task automatic done_pulse();
    bit acc;
    step(0, 0, 0, '0, 1, acc);
  endtask

  task automatic send_word(input bit last);
    bit acc;
    logic [W-1:0] d;
    acc = 0;
    d = {$urandom, $urandom};
    for (int t = 0; t < 40 && !acc; t++) step(1, ID, last, d, 0, acc);
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic send_prog(input int n);
    for (int i = 1; i <= n; i++) send_word(i == n);
  endtask

  task automatic do_reset();
    bus.pl_valid_i = 0; bus.pl_id_i = '0; bus.pl_last_i = 0;
    bus.pl_data_i = '0; bus.pe_done_i = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pl_ready", W'(bus.pl_ready_o), W'(1));
    chk("rst_wr_en",    W'(bus.wr_en_o),    W'(0));
    chk("rst_rd_valid", W'(bus.rd_valid_o), W'(0));
    chk("rst_ovf",      W'(bus.ovf_o),      W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    model_reset();
    bus.pl_valid_i = 0; bus.pl_id_i = '0; bus.pl_last_i = 0;
    bus.pl_data_i = '0; bus.pe_done_i = 0;
    @(negedge clk);
    do_reset();

    // one 4-word program into bank 0
    send_prog(4);
    idle(2);
    chk("p4_rd_valid", W'(bus.rd_valid_o), W'(1));
    chk("p4_rd_len",   W'(bus.rd_len_o),   W'(4));
    chk("p4_rd_bank",  W'(bus.rd_bank_o),  W'(0));
    done_pulse();
    idle(1);

    // partial program, then reset in the middle of it
    send_word(0);
    send_word(0);
    do_reset();
    idle(1);

    // three 2-word programs fill every bank
    send_prog(2);
    send_prog(2);
    send_prog(2);
    chk("full_ready", W'(bus.pl_ready_o), W'(0));
    for (int i = 0; i < 4; i++) step(1, ID, 1, 64'h1234, 0, acc);
    chk("full_rd_len", W'(bus.rd_len_o), W'(2));

    // release one bank while a word is waiting; it goes to bank 0
    step(1, ID, 1, 64'h5555_aaaa, 1, acc);
    chk("rel_rd_bank", W'(bus.rd_bank_o), W'(1));
    step(1, ID, 1, 64'h5555_aaaa, 0, acc);
    chk("refill_bank", W'(bus.wr_bank_o), W'(0));
    idle(2);

    // drain, then extra pe_done at count 0
    for (int i = 0; i < 4; i++) done_pulse();
    idle(1);
    done_pulse();
    chk("empty_no_switch", W'(bus.rd_switch_o), W'(0));

    // overflow: 33 words, last only on the 33rd
    do_reset();
    for (int i = 1; i <= 33; i++) send_word(i == 33);
    idle(2);
    chk("ovf_set",    W'(bus.ovf_o),    W'(1));
    chk("ovf_len32",  W'(bus.rd_len_o), W'(32));
    done_pulse();
    chk("ovf_len1",   W'(bus.rd_len_o), W'(1));
    chk("ovf_bank1",  W'(bus.rd_bank_o), W'(1));
    done_pulse();
    idle(1);

    // commit and release on the same edge with one program stored
    do_reset();
    send_prog(1);
    idle(2);
    step(1, ID, 1, 64'hbeef, 0, acc);
    step(0, 0, 0, '0, 1, acc);
    idle(1);
    chk("sim_rd_bank", W'(bus.rd_bank_o),  W'(1));
    chk("sim_count1",  W'(bus.rd_valid_o), W'(1));

    // words for another PE are ignored
    for (int i = 0; i < 3; i++) step(1, 2, 1, 64'hdead, 0, acc);
    chk("other_id_wr_en", W'(bus.wr_en_o), W'(0));

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 1),
           ($urandom_range(0, 3) == 0) ? 2 : ID,
           ($urandom_range(0, 5) == 0),
           {$urandom, $urandom},
           ($urandom_range(0, 3) == 0), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_bank_ctrl

// File: doc/imem_bank_ctrl.md
Name: imem_bank_ctrl

Overview:
- Sequences the multi-bank instruction memory of one PE.
- Accepts the Program Launcher (PL) instruction stream and steers each word to the next free bank.
- Tracks which banks hold complete programs and hands the oldest one to the PE fetch side.
- Releases a bank when the PE reports program completion; backpressures PL when no bank is free.

Parameters:
- INST_WIDTH, 64, instruction word width.
- INST_WORD, 32, words per bank; power of two.
- NUM_BANK, 3, number of banks; at least 2.
- ID, 3, PE identifier matched against pl_id_i.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- pl_valid_i  in  1  PL word valid.
- pl_id_i  in  2  PL target PE id.
- pl_last_i  in  1  last word of the program.
- pl_data_i  in  INST_WIDTH  instruction word.
- pl_ready_o  out  1  controller can accept a word.
- wr_en_o  out  1  bank write strobe.
- wr_bank_o  out  $clog2(NUM_BANK)  bank being written.
- wr_addr_o  out  $clog2(INST_WORD)  word address.
- wr_data_o  out  INST_WIDTH  registered write data.
- wr_switch_o  out  1  pulse: program closed in wr_bank.
- pe_done_i  in  1  PE finished the current program.
- rd_valid_o  out  1  rd_bank holds a complete program.
- rd_bank_o  out  $clog2(NUM_BANK)  bank the PE fetches from.
- rd_len_o  out  $clog2(INST_WORD)+1  word count of the rd_bank program.
- rd_switch_o  out  1  pulse: read bank released.
- ovf_o  out  1  sticky: program exceeded INST_WORD words.

Behaviour:
- Reset values:
  - All outputs 0, except pl_ready_o = 1.
  - wr_ptr = rd_ptr = 0; count = 0; word index = 0; all len[] = 0.
- Accept: when pl_valid_i && pl_id_i==ID && pl_ready_o.
  - Words with another id are ignored; pl_ready_o is not id-qualified.
- Write pipeline: a word accepted at edge E0 drives the following for exactly one cycle after E0:
  - wr_en_o = 1;
  - wr_bank_o = wr_ptr;
  - wr_addr_o = index;
  - wr_data_o = data.
  - The SRAM captures the word at E1.
- Program close: when pl_last_i is accepted, or the word at index INST_WORD-1 is accepted.
  - At E0: len[wr_ptr] <= index+1; index <= 0; commit_pending <= 1.
  - At E1: wr_ptr advances (wrap NUM_BANK-1 -> 0); count increments; commit_pending clears; wr_switch_o = 1 for the cycle after E1.
  - wr_bank_o during the E0-E1 cycle still shows the old bank.
- Overflow: if index INST_WORD-1 is accepted with pl_last_i = 0, the program closes with len = INST_WORD and ovf_o sets (held until reset). Subsequent words start a new bank.
- pl_ready_o = (count + commit_pending) < NUM_BANK. Registered-state only; no bypass from same-cycle pe_done_i.
- Read side:
  - rd_valid_o = (count != 0); rd_bank_o = rd_ptr; rd_len_o = len[rd_ptr].
  - pe_done_i with rd_valid_o = 1: at the edge, rd_ptr advances (wrap), count decrements, len[old rd_ptr] <= 0; rd_switch_o = 1 for the next cycle.
  - pe_done_i with rd_valid_o = 0: ignored, no pulse.
- Simultaneous commit and release in the same edge: count unchanged; both pointers advance.
- Invariant: wr_ptr == (rd_ptr + count) mod NUM_BANK, so the bank being written is never rd_bank while count < NUM_BANK.
- A partial program in progress when reset asserts is discarded; every register returns to its reset value asynchronously.

Decomposition:
- Package imem_ctrl_pkg:
  - bank_idx_t and word_idx_t typedefs;
  - len_t of width $clog2(INST_WORD)+1;
  - helper function for wrapped increment modulo NUM_BANK.
- One sub-module imem_bank_fifo holds rd_ptr, wr_ptr, count and the len[] array, with commit/release inputs.
- The top level holds the accept logic, the word index, the write pipeline register and ovf.

Test Plan:
- Reset, then one 4-word program (last on word 4):
  - wr_en_o for 4 cycles, addr 0..3, bank 0;
  - wr_switch_o one cycle;
  - rd_valid_o = 1 two cycles after the last accept, rd_len_o = 4, rd_bank_o = 0.
- Load three 2-word programs with no pe_done_i:
  - pl_ready_o drops after the third last-accept (commit_pending counted);
  - a fourth word held valid is not accepted; count = 3.
- From full, pulse pe_done_i:
  - rd_bank 0 -> 1, rd_len_o shows program 2;
  - pl_ready_o = 1 the cycle after;
  - the next program writes bank 0.
- 33 words with last only on word 33:
  - first 32 words go to bank 0, len 32, ovf_o = 1;
  - word 33 goes to bank 1 addr 0, closing with len 1.
- pe_done_i on the same edge as a commit with count = 1: count stays 1, rd_ptr and wr_ptr both advance.
- Other checks:
  - words with pl_id_i = 2 are ignored (no wr_en_o);
  - rst_n asserted mid-program clears index/count;
  - pe_done_i at count = 0 is ignored with no rd_switch_o.
